data_mem_responder: RTL and testbench

Responder-side data memory for the Simple RISC processor. It serves the load/store requests the memory stage issues: `addr` carries the ALU result, `wdata` carries `op2`, and `rdata` returns the load result. Requests and responses use valid/ready handshakes. Access latency is configurable, so the core can be exercised against a slow memory as well as a single-cycle one.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory responder.
//   WORD_W      data word width
//   state_e     responder FSM states; IDLE/WAIT/RESP are the encodings used by the FSM
//   word_index  byte address -> word index within a power-of-two deep array
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] IDLE = 2'(S_IDLE);
  localparam logic [1:0] WAIT = 2'(S_WAIT);
  localparam logic [1:0] RESP = 2'(S_RESP);

  // Word index of a byte address, wrapped to a power-of-two depth.
  function automatic int unsigned word_index(input logic [31:0] byte_addr,
                                             input int unsigned depth);
    return (byte_addr >> 2) & (depth - 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between the memory
// stage (master) and the data memory responder (slave).
//   reqValid/reqReady  request handshake
//   isLd, isSt         request kind
//   addr, wdata        byte address and store data
//   rspValid/rspReady  response handshake
//   rdata, err         load data and error flag, qualified by rspValid
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              reqValid;
  logic              reqReady;
  logic              isLd;
  logic              isSt;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              rspValid;
  logic              rspReady;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (
    output reqValid, isLd, isSt, addr, wdata, rspReady,
    input  reqReady, rspValid, rdata, err
  );

  modport slave (
    input  reqValid, isLd, isSt, addr, wdata, rspReady,
    output reqReady, rspValid, rdata, err
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, DEPTH x 32, not reset.
//   clk    rising-edge clock
//   we     write enable
//   re     read enable; rdata only changes on a read
//   idx    word index
//   wdata  write data
//   rdata  registered read data
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder-side data memory for the Simple RISC core.
// Accepts one load/store at a time, performs the access LATENCY edges after
// acceptance and holds the response until the requester takes it.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_mem_responder_if.slave handshake bundle
// Parameters: DEPTH (words, power of two), LATENCY (>= 1).
// Build option: define DMEM_MISALIGN_CHK_EN to flag addr[1:0] != 0 as an
// error; otherwise the low address bits are ignored.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request latched, latency counter running; access when cnt == 0
// RESP  | response presented, waiting for rspReady
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              ld_q;
  logic              st_q;
  logic [31:2]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;
  logic              rd_ok_q;

`ifdef DMEM_MISALIGN_CHK_EN
  logic [1:0]        lo_q;
  logic              misalign;
  assign misalign = |lo_q;
`else
  logic              misalign;
  assign misalign = 1'b0;
`endif

  logic              oor;
  logic              acc_err;
  logic              access;
  logic              we;
  logic              re;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] arr_rdata;

  assign oor     = |addr_q[31:IDX_W+2];
  assign acc_err = (ld_q & st_q) | oor | misalign;
  assign access  = (state == WAIT) && (cnt == '0);
  assign we      = access & st_q & ~ld_q & ~acc_err;
  assign re      = access & ld_q & ~st_q & ~acc_err;
  assign idx     = IDX_W'(word_index({addr_q, 2'b00}, DEPTH));

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      lo_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.reqValid) begin
            ld_q    <= bus.isLd;
            st_q    <= bus.isSt;
            addr_q  <= bus.addr[31:2];
            wdata_q <= bus.wdata;
`ifdef DMEM_MISALIGN_CHK_EN
            lo_q    <= bus.addr[1:0];
`endif
            cnt     <= CNT_W'(LATENCY - 1);
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            err_q   <= acc_err;
            rd_ok_q <= re;
            state   <= RESP;
          end
        end
        RESP: begin
          if (bus.rspReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array read register only moves on a load, so gating it with rd_ok_q keeps
  // rdata stable through RESP and zero for stores, errors and after reset.
  assign bus.reqReady = (state == IDLE);
  assign bus.rspValid = (state == RESP);
  assign bus.err      = err_q;
  assign bus.rdata    = rd_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: self-checking bench for data_mem_responder
// (DEPTH=1024, LATENCY=3). Directed steps from the test plan, then random
// traffic checked against an associative-array memory model.
module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;
  localparam int TMO     = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  data_mem_responder_if bus ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mdl [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts edges after acceptance until rspValid; reqReady must stay low.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (bus.rspValid !== 1'b1 && lat < TMO) begin
      check("req_ready_busy", 32'(bus.reqReady), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    if (bus.rspValid !== 1'b1) check("rsp_timeout", 32'(bus.rspValid), 32'd1);
  endtask

  // Takes the response; with rspReady high it must last one cycle.
  task automatic take_rsp();
    @(negedge clk);
    bus.rspReady = 1'b1;
    @(posedge clk); #1;
    bus.rspReady = 1'b0;
    check("rsp_one_cycle", 32'(bus.rspValid), 32'd0);
    check("req_ready_back", 32'(bus.reqReady), 32'd1);
  endtask

  task automatic xact(input logic ld, input logic st, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.isLd     = ld;
    bus.isSt     = st;
    bus.addr     = a;
    bus.wdata    = wd;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    wait_rsp(lat);
    rd = bus.rdata;
    er = bus.err;
    take_rsp();
  endtask

  // Reference outcome from the access rules.
  task automatic model(input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic mis;
    int   w;
`ifdef DMEM_MISALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    w  = int'(a / 4);
    er = (ld && st) || (a >= 32'(DEPTH * 4)) || mis;
    rd = '0;
    if (!er && st) mdl[w] = wd;
    if (!er && ld) rd = mdl.exists(w) ? mdl[w] : 32'hxxxx_xxxx;
  endtask

  initial begin
    logic [31:0] rd, erd, a, wd;
    logic        er, eer, ld, st;
    int          lat, k;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.reqValid = 1'b0; bus.isLd = 1'b0; bus.isSt = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.rspReady = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.reqReady), 32'd1);
    check("rst_rsp_valid", 32'(bus.rspValid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Store then load, with latency
    xact(1'b0, 1'b1, 32'h20, 32'hCAFEBABE, rd, er, lat);
    check("st_latency", 32'(lat), 32'(LATENCY));
    check("st_rdata", rd, 32'd0);
    check("st_err", 32'(er), 32'd0);
    mdl[8] = 32'hCAFEBABE;
    xact(1'b1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("ld_latency", 32'(lat), 32'(LATENCY));
    check("ld_rdata", rd, 32'hCAFEBABE);
    check("ld_err", 32'(er), 32'd0);

    // Errors
    xact(1'b1, 1'b0, 32'h0001_0000, 32'h0, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact(1'b1, 1'b1, 32'h20, 32'h5555_AAAA, rd, er, lat);
    check("both_err", 32'(er), 32'd1);
    check("both_rdata", rd, 32'd0);
    xact(1'b1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("both_nowrite", rd, 32'hCAFEBABE);
    xact(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("noop_err", 32'(er), 32'd0);
    check("noop_rdata", rd, 32'd0);

    // Backpressure with a second request offered while busy
    @(negedge clk);
    bus.reqValid = 1'b1; bus.isLd = 1'b1; bus.isSt = 1'b0; bus.addr = 32'h20;
    @(posedge clk); #1;
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(bus.rspValid), 32'd1);
      check("bp_rdata", bus.rdata, 32'hCAFEBABE);
      check("bp_req_ready", 32'(bus.reqReady), 32'd0);
    end
    take_rsp();
    @(posedge clk); #1;
    check("bp_second_accept", 32'(bus.reqReady), 32'd0);
    bus.reqValid = 1'b0;
    wait_rsp(lat);
    check("bp_second_latency", 32'(lat), 32'(LATENCY));
    check("bp_second_rdata", bus.rdata, 32'hCAFEBABE);
    take_rsp();

    // Misalignment
    xact(1'b0, 1'b1, 32'h22, 32'h12345678, rd, er, lat);
    model(1'b0, 1'b1, 32'h22, 32'h12345678, erd, eer);
    check("mis_err", 32'(er), 32'(eer));
    xact(1'b1, 1'b0, 32'h20, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_CHK_EN
    check("mis_word", rd, 32'hCAFEBABE);
`else
    check("mis_word", rd, 32'h12345678);
`endif

    // Reset while a store sits in WAIT
    xact(1'b0, 1'b1, 32'h40, 32'h11111111, rd, er, lat);
    @(negedge clk);
    bus.reqValid = 1'b1; bus.isLd = 1'b0; bus.isSt = 1'b1;
    bus.addr = 32'h40; bus.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(bus.reqReady), 32'd1);
    check("mid_rst_rsp_valid", 32'(bus.rspValid), 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    xact(1'b1, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("mid_rst_dropped", rd, 32'h11111111);

    // Random traffic against the model, on a pre-filled window
    for (int i = 0; i < 16; i++) begin
      a  = 32'h100 + 32'(i * 4);
      wd = $urandom;
      model(1'b0, 1'b1, a, wd, erd, eer);
      xact(1'b0, 1'b1, a, wd, rd, er, lat);
      check("fill_err", 32'(er), 32'(eer));
    end
    for (int i = 0; i < 60; i++) begin
      k  = int'($urandom_range(0, 9));
      ld = (k >= 4 && k <= 8);
      st = (k <= 3 || k == 8);
      a  = 32'h100 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      wd = $urandom;
      model(ld, st, a, wd, erd, eer);
      xact(ld, st, a, wd, rd, er, lat);
      check("rnd_err", 32'(er), 32'(eer));
      check("rnd_rdata", rd, erd);
      check("rnd_latency", 32'(lat), 32'(LATENCY));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
